// File: rtl/module_fifo_flex.sv
// module_fifo_flex: single-clock show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   we / re      write / read requests, accepted per the full/empty state
//   flush        synchronous clear, priority over we/re
//   din          write data
//   dout         front entry (show-ahead), 0 when empty
//   empty, full, almost_full, almost_empty, count   status from the registered count
//   overflow / underflow   sticky rejected-write / rejected-read flags
module module_fifo_flex #(
   parameter int XLEN         = 32,
   parameter int LENGTH       = 4,
   parameter int AFULL_LEVEL  = LENGTH - 1,
   parameter int AEMPTY_LEVEL = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic                         re,
   input  logic                         flush,
   input  logic [XLEN-1:0]              din,
   output logic [XLEN-1:0]              dout,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(LENGTH+1)-1:0]  count,
   output logic                         overflow,
   output logic                         underflow
);
   localparam int PW = $clog2(LENGTH);
   localparam int CW = $clog2(LENGTH + 1);
   logic [XLEN-1:0] mem [LENGTH];
   logic [PW-1:0] front_pointer_q, front_pointer_d, back_pointer_q, back_pointer_d;
   logic [CW-1:0] count_q, count_d;
   logic overflow_q, overflow_d, underflow_q, underflow_d;
   logic wr_ok, rd_ok, wr_en;
   // Explicit wrap keeps non-power-of-two depths inside the array.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(LENGTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign empty        = count_q == '0;
   assign full         = count_q == CW'(LENGTH);
   assign almost_full  = count_q >= CW'(AFULL_LEVEL);
   assign almost_empty = count_q <= CW'(AEMPTY_LEVEL);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign dout         = empty ? '0 : mem[front_pointer_q];
   // A pop while full frees the slot the simultaneous push lands in.
   assign wr_ok = we & (~full | re);
   assign rd_ok = re & ~empty;
   assign wr_en = wr_ok & ~flush;
   always_comb begin
      front_pointer_d = flush ? '0 : rd_ok ? inc(front_pointer_q) : front_pointer_q;
      back_pointer_d  = flush ? '0 : wr_ok ? inc(back_pointer_q) : back_pointer_q;
      count_d         = flush ? '0 :
                        (wr_ok & ~rd_ok) ? count_q + 1'b1 :
                        (rd_ok & ~wr_ok) ? count_q - 1'b1 : count_q;
      overflow_d      = ~flush & (overflow_q | (we & ~wr_ok));
      underflow_d     = ~flush & (underflow_q | (re & ~rd_ok));
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         front_pointer_q <= '0;
         back_pointer_q  <= '0;
         count_q         <= '0;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
      end else begin
         front_pointer_q <= front_pointer_d;
         back_pointer_q  <= back_pointer_d;
         count_q         <= count_d;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
      end
   end
   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[back_pointer_q] <= din;
   end
endmodule

// File: tb/tb_module_fifo_flex.sv
// tb_module_fifo_flex: directed scoreboard bench for module_fifo_flex (LENGTH=5).
module tb_module_fifo_flex;
   localparam int XLEN = 32;
   localparam int LENGTH = 5;
   localparam int CW = $clog2(LENGTH + 1);
   logic clk = 1'b0;
   logic reset, we, re, flush;
   logic [XLEN-1:0] din, dout;
   logic empty, full, almost_full, almost_empty, overflow, underflow;
   logic [CW-1:0] count;
   int n_cmp = 0;
   int n_fail = 0;
   logic [XLEN-1:0] sb [$];
   logic [XLEN-1:0] words [5] = '{32'hdeadbeef, 32'hbababebe, 32'hcacacaca, 32'hfeedbeef, 32'h01010101};
   int m_count = 0;
   module_fifo_flex #(.XLEN(XLEN), .LENGTH(LENGTH), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) dut (
      .clk(clk), .reset(reset), .we(we), .re(re), .flush(flush), .din(din), .dout(dout),
      .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic status(input string tag);
      check({tag, " count"}, 64'(count), 64'(m_count));
      check({tag, " empty"}, 64'(empty), 64'(m_count == 0));
      check({tag, " full"}, 64'(full), 64'(m_count == LENGTH));
      check({tag, " afull"}, 64'(almost_full), 64'(m_count >= 4));
      check({tag, " aempty"}, 64'(almost_empty), 64'(m_count <= 1));
      check({tag, " dout"}, 64'(dout), (m_count == 0) ? 64'h0 : 64'(sb[0]));
   endtask
   initial begin
      reset = 1'b0; we = 1'b0; re = 1'b0; flush = 1'b0; din = '0;
      #13;
      status("reset");
      check("reset ovf", 64'(overflow), 64'h0);
      check("reset unf", 64'(underflow), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      re = 1'b1;
      step();
      re = 1'b0;
      status("empty read");
      check("empty read unf", 64'(underflow), 64'h1);
      check("empty read fp", 64'(dut.front_pointer_q), 64'h0);
      check("empty read bp", 64'(dut.back_pointer_q), 64'h0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush1 unf", 64'(underflow), 64'h0);
      for (int i = 0; i < 5; i++) begin
         we = 1'b1; din = words[i];
         step();
         sb.push_back(words[i]);
         m_count++;
         status($sformatf("fill%0d", i));
         check($sformatf("fill%0d bp", i), 64'(dut.back_pointer_q), 64'((i + 1) % LENGTH));
      end
      din = '0;
      step();
      we = 1'b0;
      status("full write");
      check("full write ovf", 64'(overflow), 64'h1);
      check("full write bp", 64'(dut.back_pointer_q), 64'h0);
      check("full write fp", 64'(dut.front_pointer_q), 64'h0);
      we = 1'b1; re = 1'b1; din = 32'h11111111;
      step();
      we = 1'b0; re = 1'b0;
      void'(sb.pop_front());
      sb.push_back(32'h11111111);
      status("full rw");
      check("full rw dout", 64'(dout), 64'hbababebe);
      re = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("pop%0d", i), 64'(dout), 64'(sb.pop_front()));
         step();
         m_count--;
      end
      re = 1'b0;
      status("drained");
      check("drained unf", 64'(underflow), 64'h0);
      we = 1'b1; re = 1'b1; din = 32'h22222222;
      step();
      we = 1'b0; re = 1'b0;
      sb.push_back(32'h22222222);
      m_count = 1;
      status("empty rw");
      check("empty rw dout", 64'(dout), 64'h22222222);
      check("empty rw unf", 64'(underflow), 64'h1);
      for (int i = 0; i < 4; i++) begin
         we = 1'b1; din = 32'h33330000 + 32'(i);
         step();
         sb.push_back(din);
         m_count++;
      end
      din = 32'h44444444;
      step();
      we = 1'b0;
      re = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("pop2_%0d", i), 64'(dout), 64'(sb.pop_front()));
         step();
         m_count--;
      end
      re = 1'b0;
      status("count3");
      check("count3 ovf", 64'(overflow), 64'h1);
      check("count3 unf", 64'(underflow), 64'h1);
      flush = 1'b1; we = 1'b1; din = 32'h55555555;
      step();
      flush = 1'b0; we = 1'b0;
      sb.delete();
      m_count = 0;
      status("flush");
      check("flush ovf", 64'(overflow), 64'h0);
      check("flush unf", 64'(underflow), 64'h0);
      step();
      status("flush discard");
      we = 1'b1; din = 32'h66666666;
      step();
      we = 1'b0;
      sb.push_back(32'h66666666);
      m_count = 1;
      status("pre reset");
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      m_count = 0;
      status("async reset");
      check("async reset bp", 64'(dut.back_pointer_q), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/module_fifo_flex.md
Name: module_fifo_flex

Overview:
- Parametrised successor to the single-clock show-ahead FIFO primitive.
- Adds non-power-of-two depth, occupancy count, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow flags, and read+write while full.
- Used as a generic buffer between pipeline stages, the UART and the DMA paths.
- Single clock domain; storage is a register array.

Parameters:
- XLEN, 32, data word width in bits (>=1).
- LENGTH, 4, number of entries (>=2; need not be a power of two).
- AFULL_LEVEL, LENGTH-1, almost_full asserted when count >= AFULL_LEVEL (1..LENGTH).
- AEMPTY_LEVEL, 1, almost_empty asserted when count <= AEMPTY_LEVEL (0..LENGTH-1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; the port is named reset, and reset==0 resets the block.
- we  in  1  write request; din is pushed at the edge if the write is accepted.
- re  in  1  read request; the front entry is popped at the edge if the read is accepted.
- flush  in  1  synchronous clear of the contents.
- din  in  XLEN  write data.
- dout  out  XLEN  front entry (show-ahead); 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==LENGTH.
- almost_full  out  1  count>=AFULL_LEVEL.
- almost_empty  out  1  count<=AEMPTY_LEVEL.
- count  out  $clog2(LENGTH+1)  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (reset==0, asynchronous):
  - front_pointer, back_pointer, count, overflow and underflow are 0.
  - empty=1, full=0, almost_empty=1.
  - almost_full=(AFULL_LEVEL==0), which is always 0 within the legal range.
  - dout=0.
  - Memory contents are not cleared.
  - Deassertion takes effect from the next rising edge.
  - Asserting reset mid-operation discards all contents immediately.
- Pointers:
  - front_pointer and back_pointer are $clog2(LENGTH) bits.
  - Each increments modulo LENGTH, wrapping from LENGTH-1 to 0 explicitly; do not rely on natural overflow.
- dout is combinational: mem[front_pointer] when count!=0, else 0. Read latency is 0, because the data is visible before re is asserted.
- Accept rules, evaluated per edge when flush==0:
  - wr_ok = we & (~full | re).
  - rd_ok = re & ~empty.
  - When full with we&re: both are accepted; count stays LENGTH and the new word goes into the slot freed by the pop.
  - When empty with we&re: only the write is accepted, with no bypass (dout shows din from the next cycle), and underflow is set.
- Updates:
  - wr_ok: mem[back_pointer]<=din; back_pointer advances.
  - rd_ok: front_pointer advances.
  - count is updated by +1, -1 or 0 according to (wr_ok, rd_ok).
- Sticky flags:
  - overflow<=1 when we & ~wr_ok.
  - underflow<=1 when re & ~rd_ok.
  - Both hold until flush or reset.
- Flush (flush==1 at an edge):
  - Pointers, count, overflow and underflow go to 0.
  - we and re in the same cycle are ignored entirely, with no flag setting.
  - Flush has priority over everything except reset.
- All status outputs are derived from the registered count and are valid one edge after the causing operation.

Test Plan:
- LENGTH=5, AFULL_LEVEL=4, AEMPTY_LEVEL=1; release reset; assert re for 1 cycle
  -> empty=1, count=0, dout=0, pointers=0, underflow=1.
- Flush 1 cycle; write 0xdeadbeef, 0xbababebe, 0xcacacaca, 0xfeedbeef, 0x01010101
  -> count steps 1..5; almost_empty falls after count=2; almost_full rises at count=4; full=1 at 5; back_pointer sequence 1,2,3,4,0 (wrap at 5).
- While full, we=1, din=0x0 with re=0
  -> count=5, pointers unchanged, overflow=1; dout=0xdeadbeef.
- While full, we=re=1, din=0x11111111
  -> count=5, dout=0xbababebe next cycle; popping the remaining entries then yields 0xcacacaca, 0xfeedbeef, 0x01010101, 0x11111111, then empty=1.
- Empty FIFO, we=re=1, din=0x22222222
  -> count=1, dout=0x22222222 next cycle, underflow=1.
- With count=3 and both sticky flags set: assert flush together with we=1, then separately drop reset asynchronously mid-cycle
  -> flush: count=0, empty=1, flags 0, write discarded; reset: all outputs at reset values immediately, without waiting for a clock edge.
